display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_pkg.sv | 31 +++
 rtl/hex_to_7seg.sv | 30 +++
 rtl/display_scanner.sv | 116 +++++++++++
 tb/tb_display_scanner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display blocks: scan states,
// blanking constants and the active-low hex glyph set {g,f,e,d,c,b,a}.
package display_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DEAD = 2'd1,
      ST_ON   = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [3:0] AN_ALL_OFF = 4'hF;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decode.
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      case (hex)
         4'h0:    seg = GLYPH_0;
         4'h1:    seg = GLYPH_1;
         4'h2:    seg = GLYPH_2;
         4'h3:    seg = GLYPH_3;
         4'h4:    seg = GLYPH_4;
         4'h5:    seg = GLYPH_5;
         4'h6:    seg = GLYPH_6;
         4'h7:    seg = GLYPH_7;
         4'h8:    seg = GLYPH_8;
         4'h9:    seg = GLYPH_9;
         4'hA:    seg = GLYPH_A;
         4'hB:    seg = GLYPH_B;
         4'hC:    seg = GLYPH_C;
         4'hD:    seg = GLYPH_D;
         4'hE:    seg = GLYPH_E;
         default: seg = GLYPH_F;
      endcase
   end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner with dead time between digits.
//   state | meaning
//   OFF   | scanning disabled, all outputs dark, digit 0 selected
//   DEAD  | all anodes off for DEAD_CYCLES before the selected digit lights
//   ON    | selected anode driven for ON_CYCLES with the latched glyph
module display_scanner
   import display_pkg::*;
#(
   parameter int ON_CYCLES   = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] hex_val,
   input  logic [3:0] blank_mask,
   input  logic [3:0] dp_mask,
   output logic [2:0] digit_sel,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int            CW        = (ON_CYCLES > 2) ? $clog2(ON_CYCLES) : 1;
   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

   scan_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [6:0]    seg_d;
   logic          dp_d;
   logic          tick_d;
   logic [6:0]    glyph;

   hex_to_7seg u_dec (
      .hex (hex_val),
      .seg (glyph)
   );

   assign digit_sel = {1'b0, sel_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         sel_q      <= '0;
         seg        <= SEG_BLANK;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_tick <= tick_d;
      end
   end

   // Disable wins over everything, including a digit advance on the same edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      sel_d   = sel_q;
      seg_d   = seg;
      dp_d    = dp;
      tick_d  = 1'b0;
      if (!enable) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         sel_d   = '0;
         seg_d   = SEG_BLANK;
         dp_d    = 1'b1;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_DEAD;
               cnt_d   = '0;
            end
            ST_DEAD: begin
               if (cnt_q == DEAD_LAST) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
                  seg_d   = glyph;
                  dp_d    = ~dp_mask[sel_q];
               end
            end
            ST_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_d = ST_DEAD;
                  cnt_d   = '0;
                  sel_d   = sel_q + 2'd1;
                  tick_d  = (sel_q == 2'd3);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
               sel_d   = '0;
               seg_d   = SEG_BLANK;
               dp_d    = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      an = AN_ALL_OFF;
      if (state_q == ST_ON && !blank_mask[sel_q]) begin
         an[sel_q] = 1'b0;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a time-based scan model queues the
// expected outputs for every cycle and a negedge monitor compares them.
module tb_display_scanner;

   localparam int ON_C   = 4;
   localparam int DEAD_C = 2;
   localparam int SLOT   = ON_C + DEAD_C;
   localparam int FRAME  = 4 * SLOT;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [2:0] sel;
      logic       tick;
   } exp_t;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic        enable     = 1'b0;
   logic [3:0]  blank_mask = 4'h0;
   logic [3:0]  dp_mask    = 4'h0;
   logic [15:0] word       = 16'h12AF;
   logic [3:0]  hex_val;
   logic [2:0]  digit_sel;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference state: cycles elapsed since scanning started (-1 = dark),
   // plus the glyph and decimal point captured when the current digit lit.
   int         run   = -1;
   logic [6:0] seg_m = 7'h7F;
   logic       dp_m  = 1'b1;
   logic [6:0] glyph_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   assign hex_val = word[{digit_sel[1:0], 2'b00} +: 4];

   display_scanner #(.ON_CYCLES(ON_C), .DEAD_CYCLES(DEAD_C)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .hex_val    (hex_val),
      .blank_mask (blank_mask),
      .dp_mask    (dp_mask),
      .digit_sel  (digit_sel),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      int   pos, d, o;
      e.an   = 4'hF;
      e.seg  = seg_m;
      e.dp   = dp_m;
      e.sel  = 3'd0;
      e.tick = 1'b0;
      if (run >= 0) begin
         pos   = run % FRAME;
         d     = pos / SLOT;
         o     = pos % SLOT;
         e.sel = 3'(d);
         if (o >= DEAD_C && !blank_mask[d]) e.an[d] = 1'b0;
         e.tick = (run > 0 && pos == 0);
      end
      return e;
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then
   // apply the next inputs and queue what the DUT should show this cycle.
   task automatic step(input logic en_v, input logic rst_v, input logic [15:0] word_v,
                       input logic [3:0] blank_v, input logic [3:0] dpm_v);
      int pos, d;
      @(posedge clk);
      #1;
      if (reset || !enable) begin
         run   = -1;
         seg_m = 7'h7F;
         dp_m  = 1'b1;
      end else begin
         run = (run < 0) ? 0 : run + 1;
         pos = run % FRAME;
         if (pos % SLOT == DEAD_C) begin
            d     = pos / SLOT;
            seg_m = glyph_tb[word[4*d +: 4]];
            dp_m  = ~dp_mask[d];
         end
      end
      enable     = en_v;
      reset      = rst_v;
      word       = word_v;
      blank_mask = blank_v;
      dp_mask    = dpm_v;
      if (reset) begin
         run   = -1;
         seg_m = 7'h7F;
         dp_m  = 1'b1;
      end
      q.push_back(model_out());
   endtask

   task automatic run_to(input int p);
      for (int i = 0; i < 2 * FRAME && !(run >= 0 && run % FRAME == p); i++)
         step(1'b1, 1'b0, word, blank_mask, dp_mask);
      chk("reach_pos", (run >= 0) ? run % FRAME : -1, p);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("an", int'(an), int'(e.an));
            chk("seg", int'(seg), int'(e.seg));
            chk("dp", int'(dp), int'(e.dp));
            chk("digit_sel", int'(digit_sel), int'(e.sel));
            chk("frame_tick", int'(frame_tick), int'(e.tick));
         end
      end
   end

   initial begin : stim
      logic        en_r, rs_r;
      logic [15:0] w_r;
      logic [3:0]  bm_r, dm_r;
      #1 reset = 1'b1;
      enable = 1'b1;
      repeat (2) step(1'b1, 1'b1, 16'h12AF, 4'h0, 4'h0);
      step(1'b1, 1'b0, 16'h12AF, 4'h0, 4'h0);
      repeat (60) step(1'b1, 1'b0, 16'h12AF, 4'h0, 4'h0);
      repeat (30) step(1'b1, 1'b0, 16'h12AF, 4'b0100, 4'h0);
      repeat (30) step(1'b1, 1'b0, 16'h12AF, 4'h0, 4'b0001);

      // enable falls so that the edge after digit 3's last ON cycle is disabled
      run_to(FRAME - 2);
      step(1'b0, 1'b0, word, 4'h0, 4'h0);
      repeat (3) step(1'b0, 1'b0, word, 4'h0, 4'h0);
      repeat (12) step(1'b1, 1'b0, word, 4'h0, 4'h0);

      // hex_val changes while digit 0 is lit
      run_to(DEAD_C + 1);
      step(1'b1, 1'b0, 16'h12A5, 4'h0, 4'h0);
      repeat (30) step(1'b1, 1'b0, 16'h12A5, 4'h0, 4'h0);

      // asynchronous reset while digit 2 is lit
      run_to(2 * SLOT + DEAD_C);
      step(1'b1, 1'b1, word, 4'h0, 4'h0);
      #1;
      chk("async_an", int'(an), 32'hF);
      chk("async_seg", int'(seg), 32'h7F);
      chk("async_dp", int'(dp), 1);
      chk("async_sel", int'(digit_sel), 0);
      chk("async_tick", int'(frame_tick), 0);
      step(1'b1, 1'b1, word, 4'h0, 4'h0);
      step(1'b1, 1'b0, word, 4'h0, 4'h0);
      repeat (30) step(1'b1, 1'b0, word, 4'h0, 4'h0);

      for (int i = 0; i < 600; i++) begin
         en_r = ($urandom_range(0, 39) != 0);
         rs_r = ($urandom_range(0, 149) == 0);
         w_r  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : word;
         bm_r = ($urandom_range(0, 19) == 0) ? 4'($urandom) : blank_mask;
         dm_r = ($urandom_range(0, 19) == 0) ? 4'($urandom) : dp_mask;
         step(en_r, rs_r, w_r, bm_r, dm_r);
      end
      step(1'b1, 1'b0, word, blank_mask, dp_mask);

      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
